// File: rtl/inverse_zigzag_buffer.sv
// rtl/inverse_zigzag_buffer.sv - ping-pong 4x4 inverse zigzag reorder buffer
//
// Coefficients arrive in zigzag scan order and leave in raster order. Two
// banks alternate: one fills while the other drains, which sustains one
// coefficient per cycle in and out.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   clr               synchronous flush of both banks and both counters
//   in_valid/in_ready/in_data                 zigzag-order input stream
//   out_valid/out_ready/out_data/out_idx/out_last  raster-order output stream
//   blocks_stored     number of banks holding a complete block (0..2)
module inverse_zigzag_buffer #(
    parameter int WIDTH     = 9,
    parameter int addrWIDTH = 4,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [addrWIDTH-1:0] out_idx,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [1:0]           blocks_stored
);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    localparam logic [addrWIDTH-1:0] LAST = addrWIDTH'(DEPTH - 1);

    // Raster address for the k-th coefficient of the zigzag scan.
    localparam logic [addrWIDTH-1:0] ZZ [16] = '{
        4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
    };

    bank_state_e          bank_q [2];
    bank_state_e          bank_d [2];
    logic                 wp_q, wp_d;
    logic                 rp_q, rp_d;
    logic [addrWIDTH-1:0] k_q, k_d;
    logic [addrWIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0]     mem_q [2][DEPTH];

    logic wr_fire;
    logic rd_fire;
    logic stored0;
    logic stored1;

    assign in_ready  = (bank_q[wp_q] == EMPTY) || (bank_q[wp_q] == FILLING);
    assign out_valid = (bank_q[rp_q] == FULL)  || (bank_q[rp_q] == DRAINING);
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    // Gated so the output reads zero whenever nothing valid is presented
    // (including during reset), since the storage itself is never cleared.
    assign out_data = out_valid ? mem_q[rp_q][r_q] : '0;
    assign out_idx  = r_q;
    assign out_last = (r_q == LAST);

    assign stored0       = (bank_q[0] == FULL) || (bank_q[0] == DRAINING);
    assign stored1       = (bank_q[1] == FULL) || (bank_q[1] == DRAINING);
    assign blocks_stored = 2'(stored0) + 2'(stored1);

    // A write and a read can fire together only on different banks: the
    // write bank must be EMPTY/FILLING while the read bank is FULL/DRAINING.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wp_d      = wp_q;
        rp_d      = rp_q;
        k_d       = k_q;
        r_d       = r_q;
        if (clr) begin
            bank_d[0] = EMPTY;
            bank_d[1] = EMPTY;
            wp_d      = 1'b0;
            rp_d      = 1'b0;
            k_d       = '0;
            r_d       = '0;
        end else begin
            if (wr_fire) begin
                if (k_q == LAST) begin
                    bank_d[wp_q] = FULL;
                    k_d          = '0;
                    wp_d         = ~wp_q;
                end else begin
                    bank_d[wp_q] = FILLING;
                    k_d          = k_q + 1'b1;
                end
            end
            if (rd_fire) begin
                if (r_q == LAST) begin
                    bank_d[rp_q] = EMPTY;
                    r_d          = '0;
                    rp_d         = ~rp_q;
                end else begin
                    bank_d[rp_q] = DRAINING;
                    r_d          = r_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            k_q       <= '0;
            r_q       <= '0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            k_q       <= k_d;
            r_q       <= r_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire && !clr) begin
            mem_q[wp_q][ZZ[k_q]] <= in_data;
        end
    end

endmodule

// File: tb/tb_inverse_zigzag_buffer.sv
// tb/tb_inverse_zigzag_buffer.sv - self-checking bench for inverse_zigzag_buffer
module tb_inverse_zigzag_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [8:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [8:0] out_data;
    logic [3:0] out_idx;
    logic       out_last;
    logic       out_ready;
    logic [1:0] blocks_stored;

    inverse_zigzag_buffer #(.WIDTH(9), .addrWIDTH(4), .DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_idx       (out_idx),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .blocks_stored (blocks_stored)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] d;
        logic [3:0] idx;
        logic       last;
    } exp_t;

    // Raster index r carries the input at zigzag position INV[r].
    int INV [16] = '{0, 1, 5, 6, 2, 4, 7, 12, 3, 8, 11, 13, 9, 10, 14, 15};

    exp_t       sb [$];
    logic [8:0] blk [16];
    int         mk = 0;
    int         checks = 0;
    int         errors = 0;

    logic       stall_prev = 1'b0;
    logic [8:0] st_data;
    logic [3:0] st_idx;
    logic       st_last;

    logic       b2b_mode = 1'b0;
    logic       b2b_first = 1'b0;
    logic       b2b_started = 1'b0;
    int         b2b_outs = 0;
    int         b2b_gaps = 0;
    int         b2b_ird = 0;
    logic       rdone;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard model: watches handshakes at the falling edge, where the
    // inputs are stable for the coming rising edge.
    always @(negedge clk) begin
        if (!rst || clr) begin
            sb.delete();
            mk = 0;
            stall_prev = 1'b0;
        end else begin
            if (out_valid && stall_prev) begin
                chk("stall_data", out_data, st_data);
                chk("stall_idx", out_idx, st_idx);
                chk("stall_last", out_last, st_last);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_idx", out_idx, e.idx);
                    chk("out_last", out_last, e.last);
                end
            end
            stall_prev = out_valid && !out_ready;
            st_data = out_data;
            st_idx = out_idx;
            st_last = out_last;
            if (in_valid && in_ready) begin
                blk[mk] = in_data;
                mk++;
                if (mk == 16) begin
                    for (int r = 0; r < 16; r++) begin
                        exp_t e;
                        e.d = blk[INV[r]];
                        e.idx = 4'(r);
                        e.last = (r == 15);
                        sb.push_back(e);
                    end
                    mk = 0;
                end
            end
            if (b2b_mode) begin
                if (out_valid) b2b_started = 1'b1;
                if (b2b_started && b2b_outs < 48 && !out_valid) b2b_gaps++;
                if (out_valid && out_ready) b2b_outs++;
                if (b2b_first && !in_ready) b2b_ird++;
            end
        end
    end

    task automatic push_beat(input logic [8:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_timeout", n < 500, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        @(negedge clk);
        #1;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", n < bound, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_blocks_stored", blocks_stored, 0);
        chk("rst_out_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Single block, values 0..15, with latency check.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_beat(9'(i));
        chk("latency_out_valid", out_valid, 1);
        chk("latency_blocks_stored", blocks_stored, 1);
        wait_drain(100);
        chk("single_idle_out_valid", out_valid, 0);

        // Three blocks back-to-back.
        b2b_mode = 1'b1;
        for (int i = 0; i < 48; i++) begin
            push_beat(9'($urandom_range(511)));
            if (i == 15) b2b_first = 1'b1;
        end
        wait_drain(200);
        b2b_mode = 1'b0;
        chk("b2b_outputs", b2b_outs, 48);
        chk("b2b_gaps", b2b_gaps, 0);
        chk("b2b_in_ready_drops", b2b_ird, 0);

        // Backpressure: two blocks held, 33rd beat waits.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_beat(9'(100 + i));
        for (int i = 0; i < 16; i++) push_beat(9'(-(i + 1)));
        chk("bp_blocks_stored", blocks_stored, 2);
        chk("bp_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data = 9'h0aa;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_held_in_ready", in_ready, 0);
        chk("bp_held_blocks", blocks_stored, 2);
        chk("bp_held_idx", out_idx, 0);
        out_ready = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("bp_33rd_timeout", n < 100, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        for (int i = 1; i < 16; i++) push_beat(9'(200 + i));
        wait_drain(200);
        chk("bp_done_blocks", blocks_stored, 0);

        // clr after 7 inputs, then one full clean block.
        for (int i = 0; i < 7; i++) push_beat(9'(300 + i));
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_blocks_stored", blocks_stored, 0);
        chk("clr_in_ready", in_ready, 1);
        for (int i = 0; i < 16; i++) push_beat(9'(400 + i));
        wait_drain(100);

        // Random in_valid / out_ready over 1000 blocks.
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 16000; i++) begin
                    while ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    push_beat(9'($urandom_range(511)));
                end
                wait_drain(4000);
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        chk("rand_blocks_stored", blocks_stored, 0);

        // Reset pulsed mid-drain.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_beat(9'(i * 7));
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_blocks_stored", blocks_stored, 0);
        chk("midrst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) push_beat(9'(i + 50));
        wait_drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
